// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Memory / MMIO access stage that sits downstream of the main control unit.
// It runs exactly one bus transaction per memory instruction and holds the
// front of the pipeline via stall_out until the transaction finishes. Stores
// are lane-aligned (byte enables plus replicated data). Loads are lane-extracted
// and zero-extended. LL/SC status is returned on rdata_out.
//
// Optional feature macro: ATOMIC_RESV_EN
//   defined   : LL/SC use a reservation register (valid + word address).
//               An SC that does not match the reservation completes without
//               any bus traffic and returns 0.
//   undefined : LL behaves as LW. SC always writes and returns 1.
//
// Parameters
//   TIMEOUT_CYCLES : number of BUSY cycles without bus_ack_in before the
//                    access is aborted (>= 2)
//   TMO_W          : width of the timeout counter (2**TMO_W >= TIMEOUT_CYCLES)
//
// Ports
//   clk_in         in   1   clock; all state changes on the rising edge
//   reset_in       in   1   synchronous, active-high reset
//   memRead_in     in   1   load request
//   memWrite_in    in   1   store request (has priority over memRead_in)
//   atomic_in      in   1   LL (with memRead_in) or SC (with memWrite_in)
//   mMask_in       in   2   00 byte, 01 half, 1x word
//   addr_in        in   32  effective address
//   wdata_in       in   32  store data (rt)
//   stall_out      out  1   hold PC/IF/ID/EX (combinational)
//   rdata_out      out  32  load data / SC status, valid while done_out=1
//   done_out       out  1   one-cycle completion pulse
//   fault_out      out  1   one-cycle pulse: misaligned access or bus timeout
//   bus_req_out    out  1   transaction request, held until ack or timeout
//   bus_we_out     out  1   1 = write
//   bus_addr_out   out  32  word-aligned address
//   bus_wdata_out  out  32  lane-replicated store data
//   bus_be_out     out  4   byte enables (bit0 = byte address 0)
//   bus_ack_in     in   1   completion strobe
//   bus_rdata_in   in   32  read data, valid with bus_ack_in
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TMO_W          = 8
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        memRead_in,
  input  logic        memWrite_in,
  input  logic        atomic_in,
  input  logic [1:0]  mMask_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        stall_out,
  output logic [31:0] rdata_out,
  output logic        done_out,
  output logic        fault_out,
  output logic        bus_req_out,
  output logic        bus_we_out,
  output logic [31:0] bus_addr_out,
  output logic [31:0] bus_wdata_out,
  output logic [3:0]  bus_be_out,
  input  logic        bus_ack_in,
  input  logic [31:0] bus_rdata_in
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Byte enables for the addressed lane(s).
  function automatic logic [3:0] lane_be(input logic word, input logic half,
                                         input logic [1:0] off);
    logic [3:0] be;
    if (word) begin
      be = 4'b1111;
    end else if (half) begin
      be = off[1] ? 4'b1100 : 4'b0011;
    end else begin
      be = 4'b0001 << off;
    end
    return be;
  endfunction

  // Store data replicated across all lanes so the slave can pick any lane.
  function automatic logic [31:0] lane_wdata(input logic word, input logic half,
                                             input logic [31:0] data);
    logic [31:0] wd;
    if (word) begin
      wd = data;
    end else if (half) begin
      wd = {2{data[15:0]}};
    end else begin
      wd = {4{data[7:0]}};
    end
    return wd;
  endfunction

  // Extract the addressed lane(s) and zero-extend.
  function automatic logic [31:0] lane_load(input logic word, input logic half,
                                            input logic [1:0] off,
                                            input logic [31:0] raw);
    logic [31:0] ld;
    if (word) begin
      ld = raw;
    end else if (half) begin
      ld = off[1] ? {16'd0, raw[31:16]} : {16'd0, raw[15:0]};
    end else begin
      case (off)
        2'd0:    ld = {24'd0, raw[7:0]};
        2'd1:    ld = {24'd0, raw[15:8]};
        2'd2:    ld = {24'd0, raw[23:16]};
        2'd3:    ld = {24'd0, raw[31:24]};
        default: ld = 32'd0;
      endcase
    end
    return ld;
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;

  logic        op_store_r;
  logic        op_atomic_r;
  logic        op_word_r;
  logic        op_half_r;
  logic [1:0]  op_off_r;
  logic [31:0] bus_addr_r;
  logic [31:0] bus_wdata_r;
  logic [3:0]  bus_be_r;
  logic [31:0] rdata_r;
  logic        tmo_flag_r;
  logic [TMO_W-1:0] tmo_cnt_r;

  logic        req_s;
  logic        word_s;
  logic        half_s;
  logic        misalign_s;
  logic        sc_fail_s;
  logic        tmo_hit_s;

`ifdef ATOMIC_RESV_EN
  logic        resv_valid_r;
  logic [29:0] resv_addr_r;
`endif

  // Decode of the instruction presented in IDLE. Atomics are always words.
  always_comb begin
    req_s      = memRead_in | memWrite_in;
    word_s     = atomic_in | mMask_in[1];
    half_s     = ~atomic_in & (mMask_in == 2'b01);
    misalign_s = (word_s & (addr_in[1:0] != 2'b00)) | (half_s & addr_in[0]);
`ifdef ATOMIC_RESV_EN
    // A store-conditional without a matching reservation skips the bus.
    sc_fail_s  = memWrite_in & atomic_in &
                 ~(resv_valid_r & (resv_addr_r == addr_in[31:2]));
`else
    sc_fail_s  = 1'b0;
`endif
    tmo_hit_s  = (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));
  end

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and control outputs.
  always_comb begin
    state_nxt_s = state_r;
    stall_out   = 1'b0;
    fault_out   = 1'b0;
    done_out    = 1'b0;
    bus_req_out = 1'b0;
    rdata_out   = 32'd0;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          if (misalign_s) begin
            fault_out = 1'b1;
          end else begin
            stall_out   = 1'b1;
            state_nxt_s = sc_fail_s ? ST_DONE : ST_BUSY;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        bus_req_out = 1'b1;
        stall_out   = 1'b1;
        if (bus_ack_in || tmo_hit_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        done_out    = 1'b1;
        // A timeout is reported alongside its completion pulse.
        fault_out   = tmo_flag_r;
        rdata_out   = rdata_r;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Operation latch, bus datapath, timeout counter and result register.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      op_store_r  <= 1'b0;
      op_atomic_r <= 1'b0;
      op_word_r   <= 1'b0;
      op_half_r   <= 1'b0;
      op_off_r    <= 2'd0;
      bus_addr_r  <= 32'd0;
      bus_wdata_r <= 32'd0;
      bus_be_r    <= 4'd0;
      rdata_r     <= 32'd0;
      tmo_flag_r  <= 1'b0;
      tmo_cnt_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_s && !misalign_s) begin
            op_store_r  <= memWrite_in;
            op_atomic_r <= atomic_in;
            op_word_r   <= word_s;
            op_half_r   <= half_s;
            op_off_r    <= addr_in[1:0];
            bus_addr_r  <= {addr_in[31:2], 2'b00};
            bus_wdata_r <= memWrite_in ? lane_wdata(word_s, half_s, wdata_in) : 32'd0;
            bus_be_r    <= lane_be(word_s, half_s, addr_in[1:0]);
            rdata_r     <= 32'd0;
            tmo_flag_r  <= 1'b0;
            tmo_cnt_r   <= '0;
          end else begin
            tmo_cnt_r   <= '0;
          end
        end
        ST_BUSY: begin
          if (bus_ack_in) begin
            if (op_store_r) begin
              rdata_r <= op_atomic_r ? 32'd1 : 32'd0;
            end else begin
              rdata_r <= lane_load(op_word_r, op_half_r, op_off_r, bus_rdata_in);
            end
          end else if (tmo_hit_s) begin
            tmo_flag_r <= 1'b1;
            rdata_r    <= 32'd0;
          end else begin
            tmo_cnt_r  <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          tmo_cnt_r <= '0;
        end
        default: begin
          tmo_cnt_r <= '0;
        end
      endcase
    end
  end

`ifdef ATOMIC_RESV_EN
  // Reservation: set by a completed LL, cleared by any completed store
  // (including a successful SC) to the reserved word.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      resv_valid_r <= 1'b0;
      resv_addr_r  <= 30'd0;
    end else if (state_r == ST_BUSY && bus_ack_in) begin
      if (!op_store_r && op_atomic_r) begin
        resv_valid_r <= 1'b1;
        resv_addr_r  <= bus_addr_r[31:2];
      end else if (op_store_r && resv_valid_r && (resv_addr_r == bus_addr_r[31:2])) begin
        resv_valid_r <= 1'b0;
      end else begin
        resv_valid_r <= resv_valid_r;
      end
    end else begin
      resv_valid_r <= resv_valid_r;
    end
  end
`endif

  assign bus_we_out    = op_store_r;
  assign bus_addr_out  = bus_addr_r;
  assign bus_wdata_out = bus_wdata_r;
  assign bus_be_out    = bus_be_r;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int TMO = 256;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        memRead_in;
  logic        memWrite_in;
  logic        atomic_in;
  logic [1:0]  mMask_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        stall_out;
  logic [31:0] rdata_out;
  logic        done_out;
  logic        fault_out;
  logic        bus_req_out;
  logic        bus_we_out;
  logic [31:0] bus_addr_out;
  logic [31:0] bus_wdata_out;
  logic [3:0]  bus_be_out;
  logic        bus_ack_in;
  logic [31:0] bus_rdata_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference reservation state (only meaningful with ATOMIC_RESV_EN).
  logic        m_resv_valid = 1'b0;
  logic [29:0] m_resv_addr  = 30'd0;

  mem_access_unit #(.TIMEOUT_CYCLES(TMO), .TMO_W(8)) dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .memRead_in    (memRead_in),
    .memWrite_in   (memWrite_in),
    .atomic_in     (atomic_in),
    .mMask_in      (mMask_in),
    .addr_in       (addr_in),
    .wdata_in      (wdata_in),
    .stall_out     (stall_out),
    .rdata_out     (rdata_out),
    .done_out      (done_out),
    .fault_out     (fault_out),
    .bus_req_out   (bus_req_out),
    .bus_we_out    (bus_we_out),
    .bus_addr_out  (bus_addr_out),
    .bus_wdata_out (bus_wdata_out),
    .bus_be_out    (bus_be_out),
    .bus_ack_in    (bus_ack_in),
    .bus_rdata_in  (bus_rdata_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_ops();
    memRead_in  = 1'b0;
    memWrite_in = 1'b0;
    atomic_in   = 1'b0;
    mMask_in    = 2'b00;
    addr_in     = 32'd0;
    wdata_in    = 32'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_stall"}, 32'(stall_out), 32'd0);
    check_val({tag, "_done"},  32'(done_out), 32'd0);
    check_val({tag, "_fault"}, 32'(fault_out), 32'd0);
    check_val({tag, "_req"},   32'(bus_req_out), 32'd0);
    check_val({tag, "_we"},    32'(bus_we_out), 32'd0);
    check_val({tag, "_addr"},  bus_addr_out, 32'd0);
    check_val({tag, "_wdata"}, bus_wdata_out, 32'd0);
    check_val({tag, "_be"},    32'(bus_be_out), 32'd0);
    check_val({tag, "_rdata"}, rdata_out, 32'd0);
  endtask

  // One instruction from IDLE to back in IDLE. ack_delay = BUSY cycles
  // without ack before the ack cycle; negative means never ack (timeout).
  task automatic do_access(input logic rd, input logic wr, input logic at,
                           input logic [1:0] mask, input logic [31:0] a,
                           input logic [31:0] wd, input int ack_delay,
                           input logic [31:0] raw,
                           output logic [3:0] o_be, output logic [31:0] o_wdata,
                           output logic [31:0] o_rdata, output int o_stall);
    logic        word;
    logic        half;
    logic        mis;
    logic        sc_fail;
    logic        tmo;
    logic [1:0]  off;
    logic [3:0]  e_be;
    logic [3:0]  half_pat;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
    int          busy_n;
    int          stall_n;
    off      = a[1:0];
    word     = at | mask[1];
    half     = ~at & (mask == 2'b01);
    mis      = word ? (off != 2'b00) : (half ? off[0] : 1'b0);
    half_pat = 4'b0011;
    e_be     = word ? 4'b1111 : (half ? (half_pat << off) : (4'b0001 << off));
    if (!wr)       e_wd = 32'd0;
    else if (word) e_wd = wd;
    else if (half) e_wd = (wd & 32'h0000FFFF) * 32'h00010001;
    else           e_wd = (wd & 32'h000000FF) * 32'h01010101;
    sc_fail = 1'b0;
`ifdef ATOMIC_RESV_EN
    if (wr && at) sc_fail = !(m_resv_valid && (m_resv_addr == a[31:2]));
`endif
    o_be = 4'd0; o_wdata = 32'd0; o_rdata = 32'd0; o_stall = 0;

    memRead_in = rd; memWrite_in = wr; atomic_in = at;
    mMask_in = mask; addr_in = a; wdata_in = wd;
    #1;
    check_val("idle_stall", 32'(stall_out), 32'(!mis));
    check_val("idle_fault", 32'(fault_out), 32'(mis));
    check_val("idle_req",   32'(bus_req_out), 32'd0);
    check_val("idle_done",  32'(done_out), 32'd0);
    stall_n = int'(stall_out);
    tick();

    if (mis) begin
      clear_ops();
      #1;
      check_val("mis_req",   32'(bus_req_out), 32'd0);
      check_val("mis_done",  32'(done_out), 32'd0);
      check_val("mis_fault", 32'(fault_out), 32'd0);
      return;
    end

    if (sc_fail) begin
      check_val("scf_done",  32'(done_out), 32'd1);
      check_val("scf_rdata", rdata_out, 32'd0);
      check_val("scf_req",   32'(bus_req_out), 32'd0);
      check_val("scf_fault", 32'(fault_out), 32'd0);
      check_val("scf_stall", 32'(stall_out), 32'd0);
      clear_ops();
      tick();
      check_val("scf_idle_done", 32'(done_out), 32'd0);
      o_stall = stall_n;
      return;
    end

    // Pipeline inputs change freely while the access is in flight.
    memRead_in  = 1'($urandom);
    memWrite_in = 1'($urandom);
    atomic_in   = 1'($urandom);
    mMask_in    = 2'($urandom);
    addr_in     = $urandom;
    wdata_in    = $urandom;

    tmo    = (ack_delay < 0);
    busy_n = tmo ? TMO : ack_delay + 1;
    for (int n = 0; n < busy_n; n++) begin
      check_val("busy_req",   32'(bus_req_out), 32'd1);
      check_val("busy_stall", 32'(stall_out), 32'd1);
      check_val("busy_done",  32'(done_out), 32'd0);
      check_val("busy_we",    32'(bus_we_out), 32'(wr));
      check_val("busy_addr",  bus_addr_out, {a[31:2], 2'b00});
      check_val("busy_be",    32'(bus_be_out), 32'(e_be));
      check_val("busy_wdata", bus_wdata_out, e_wd);
      o_be    = bus_be_out;
      o_wdata = bus_wdata_out;
      stall_n += int'(stall_out);
      bus_ack_in   = (n == ack_delay);
      bus_rdata_in = (n == ack_delay) ? raw : $urandom;
      tick();
    end
    bus_ack_in = 1'b0;

    if (tmo)         e_rd = 32'd0;
    else if (wr)     e_rd = at ? 32'd1 : 32'd0;
    else if (word)   e_rd = raw;
    else if (half)   e_rd = (raw >> (8 * int'(off))) & 32'h0000FFFF;
    else             e_rd = (raw >> (8 * int'(off))) & 32'h000000FF;

    check_val("done_pulse", 32'(done_out), 32'd1);
    check_val("done_fault", 32'(fault_out), 32'(tmo));
    check_val("done_rdata", rdata_out, e_rd);
    check_val("done_req",   32'(bus_req_out), 32'd0);
    check_val("done_stall", 32'(stall_out), 32'd0);
    check_val("stall_cycles", 32'(stall_n), 32'(busy_n + 1));
    o_rdata = rdata_out;
    o_stall = stall_n;

`ifdef ATOMIC_RESV_EN
    if (!tmo) begin
      if (!wr && at) begin
        m_resv_valid = 1'b1;
        m_resv_addr  = a[31:2];
      end else if (wr && m_resv_valid && (m_resv_addr == a[31:2])) begin
        m_resv_valid = 1'b0;
      end
    end
`endif

    clear_ops();
    tick();
    check_val("post_done",  32'(done_out), 32'd0);
    check_val("post_fault", 32'(fault_out), 32'd0);
  endtask

  logic [3:0]  r_be;
  logic [31:0] r_wd;
  logic [31:0] r_rd;
  int          r_st;
  logic [31:0] sc_exp;

  initial begin
    reset_in = 1'b1;
    clear_ops();
    bus_ack_in   = 1'b0;
    bus_rdata_in = 32'd0;
    tick(); tick(); tick();
    check_all_zero("reset");
    reset_in = 1'b0;
    tick();

    // LW 0x100, ack after three silent BUSY cycles.
    do_access(1'b1, 1'b0, 1'b0, 2'b10, 32'h100, 32'd0, 3, 32'hCAFEBABE, r_be, r_wd, r_rd, r_st);
    check_val("lw_rdata", r_rd, 32'hCAFEBABE);
    check_val("lw_stall5", 32'(r_st), 32'd5);

    // SB 0x103 / SH 0x102.
    do_access(1'b0, 1'b1, 1'b0, 2'b00, 32'h103, 32'h12345678, 1, 32'd0, r_be, r_wd, r_rd, r_st);
    check_val("sb_be", 32'(r_be), 32'h8);
    check_val("sb_wdata", r_wd, 32'h78787878);
    do_access(1'b0, 1'b1, 1'b0, 2'b01, 32'h102, 32'h12345678, 0, 32'd0, r_be, r_wd, r_rd, r_st);
    check_val("sh_be", 32'(r_be), 32'hC);
    check_val("sh_wdata", r_wd, 32'h56785678);

    // LBU / LHU zero extension.
    do_access(1'b1, 1'b0, 1'b0, 2'b00, 32'h101, 32'd0, 2, 32'hAABBCCDD, r_be, r_wd, r_rd, r_st);
    check_val("lbu_rdata", r_rd, 32'h000000CC);
    do_access(1'b1, 1'b0, 1'b0, 2'b01, 32'h102, 32'd0, 0, 32'hAABBCCDD, r_be, r_wd, r_rd, r_st);
    check_val("lhu_rdata", r_rd, 32'h0000AABB);

    // Misaligned word, then bus timeout.
    do_access(1'b1, 1'b0, 1'b0, 2'b10, 32'h102, 32'd0, 0, 32'd0, r_be, r_wd, r_rd, r_st);
    check_val("mis_stall", 32'(r_st), 32'd0);
    do_access(1'b1, 1'b0, 1'b0, 2'b10, 32'h104, 32'd0, -1, 32'd0, r_be, r_wd, r_rd, r_st);
    check_val("tmo_rdata", r_rd, 32'd0);

    // LL/SC sequences.
    do_access(1'b1, 1'b0, 1'b1, 2'b00, 32'h200, 32'd0, 1, 32'h11112222, r_be, r_wd, r_rd, r_st);
    check_val("ll_rdata", r_rd, 32'h11112222);
    do_access(1'b0, 1'b1, 1'b1, 2'b00, 32'h200, 32'hDEAD0001, 1, 32'd0, r_be, r_wd, r_rd, r_st);
    check_val("sc_ok_rdata", r_rd, 32'd1);
    do_access(1'b1, 1'b0, 1'b1, 2'b00, 32'h200, 32'd0, 0, 32'h33334444, r_be, r_wd, r_rd, r_st);
    do_access(1'b0, 1'b1, 1'b0, 2'b10, 32'h200, 32'h55556666, 0, 32'd0, r_be, r_wd, r_rd, r_st);
    do_access(1'b0, 1'b1, 1'b1, 2'b00, 32'h200, 32'h77778888, 0, 32'd0, r_be, r_wd, r_rd, r_st);
`ifdef ATOMIC_RESV_EN
    sc_exp = 32'd0;
`else
    sc_exp = 32'd1;
`endif
    check_val("sc_after_sw_rdata", r_rd, sc_exp);

    // Reset in the middle of BUSY; a late ack must be ignored.
    memRead_in = 1'b1; mMask_in = 2'b10; addr_in = 32'h300;
    tick();
    clear_ops();
    tick();
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    m_resv_valid = 1'b0;
    check_all_zero("rst_busy");
    bus_ack_in   = 1'b1;
    bus_rdata_in = 32'hFFFF0000;
    tick();
    bus_ack_in = 1'b0;
    check_val("late_ack_done",  32'(done_out), 32'd0);
    check_val("late_ack_fault", 32'(fault_out), 32'd0);
    check_val("late_ack_req",   32'(bus_req_out), 32'd0);
    do_access(1'b1, 1'b0, 1'b0, 2'b10, 32'h300, 32'd0, 1, 32'h0BADF00D, r_be, r_wd, r_rd, r_st);
    check_val("post_rst_lw", r_rd, 32'h0BADF00D);

    // Randomized traffic against the reference rules.
    for (int i = 0; i < 150; i++) begin
      int          kind;
      logic        at;
      logic [1:0]  mask;
      logic [31:0] a;
      kind = int'($urandom_range(0, 2));
      at   = ($urandom_range(0, 3) == 0);
      mask = 2'($urandom);
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = 32'h200 | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      do_access(kind != 1, kind != 0, at, mask, a, $urandom,
                int'($urandom_range(0, 4)), $urandom, r_be, r_wd, r_rd, r_st);
      // Stray ack while idle.
      bus_ack_in   = 1'($urandom);
      bus_rdata_in = $urandom;
      tick();
      bus_ack_in = 1'b0;
      check_val("idle_gap_done", 32'(done_out), 32'd0);
      check_val("idle_gap_req",  32'(bus_req_out), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
